// File: rtl/fabric_port_out_tdm.sv
// Egress TDM deserializer: packs RATIO narrow flits into one wide word behind a 2-entry output buffer.
// Optional sticky illegal-operation flag o_error_out is enabled by defining FABRIC_PORT_OUT_ERR_EN.
module fabric_port_out_tdm #(
   parameter int WIDTH = 4,
   parameter int RATIO = 4
) (
   input  logic                   clk,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       i_data_in,
   input  logic                   i_write_en,
   output logic                   i_full_out,
   output logic [WIDTH*RATIO-1:0] o_data_out,
   input  logic                   o_read_en,
   output logic                   o_empty_out
`ifdef FABRIC_PORT_OUT_ERR_EN
   ,
   output logic                   o_error_out
`endif
);

   localparam int              CW       = $clog2(RATIO);
   localparam int              WW       = WIDTH * RATIO;
   localparam logic [CW-1:0]   CNT_LAST = CW'(RATIO - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [WW-1:0] asm_q, asm_d;
   logic [WW-1:0] head_q, head_d;
   logic [WW-1:0] tail_q, tail_d;
   logic [1:0]    occ_q, occ_d;
   logic [WW-1:0] word;
   logic          wr_ok, rd_ok, push;

   // Full only blocks the word-completing flit, so earlier flits keep streaming in.
   assign i_full_out  = (occ_q == 2'd2) && (cnt_q == CNT_LAST);
   assign o_empty_out = (occ_q == 2'd0);
   assign o_data_out  = head_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cnt_d  = cnt_q;
      asm_d  = asm_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;

      wr_ok = i_write_en && !i_full_out;
      rd_ok = o_read_en && !o_empty_out;
      push  = wr_ok && (cnt_q == CNT_LAST);

      word = asm_q;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt_q == CW'(k)) word[k*WIDTH +: WIDTH] = i_data_in;
      end

      if (wr_ok) begin
         asm_d = word;
         cnt_d = push ? '0 : cnt_q + 1'b1;
      end

      // Head stays put when the last entry is popped, so an empty buffer shows the last popped word.
      if (push && rd_ok) begin
         head_d = word;
      end else if (push) begin
         if (occ_q == 2'd0) head_d = word;
         else               tail_d = word;
         occ_d = occ_q + 2'd1;
      end else if (rd_ok) begin
         if (occ_q == 2'd2) head_d = tail_q;
         occ_d = occ_q - 2'd1;
      end
   end

   // NOTE: the word storage is reset too, because an empty buffer must read back all zeros after clear.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         cnt_q  <= '0;
         asm_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         cnt_q  <= cnt_d;
         asm_q  <= asm_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

`ifdef FABRIC_PORT_OUT_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q | (i_write_en && i_full_out) | (o_read_en && o_empty_out);
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign o_error_out = err_q;
`endif

endmodule

// File: tb/tb_fabric_port_out_tdm.sv
// Bench for fabric_port_out_tdm: directed vector table, mid-word reset sequence, and random traffic vs a queue model.
module tb_fabric_port_out_tdm;

   localparam int WIDTH = 4;
   localparam int RATIO = 4;
   localparam int WW    = WIDTH * RATIO;

   logic             clk;
   logic             clear;
   logic [WIDTH-1:0] i_data_in;
   logic             i_write_en;
   logic             i_full_out;
   logic [WW-1:0]    o_data_out;
   logic             o_read_en;
   logic             o_empty_out;
`ifdef FABRIC_PORT_OUT_ERR_EN
   logic             o_error_out;
`endif

   fabric_port_out_tdm #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
      .clk         (clk),
      .clear       (clear),
      .i_data_in   (i_data_in),
      .i_write_en  (i_write_en),
      .i_full_out  (i_full_out),
      .o_data_out  (o_data_out),
      .o_read_en   (o_read_en),
`ifdef FABRIC_PORT_OUT_ERR_EN
      .o_error_out (o_error_out),
`endif
      .o_empty_out (o_empty_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of completed words plus the flits of the word in progress.
   logic [WW-1:0]    m_q[$];
   logic [WIDTH-1:0] m_parts[RATIO];
   int               m_n;
   logic [WW-1:0]    m_last;
   logic             m_err;

   function automatic void model_reset();
      m_q.delete();
      m_n    = 0;
      m_last = '0;
      m_err  = 1'b0;
   endfunction

   // Apply the current inputs across one rising edge, then settle 1 time unit past it.
   task automatic step();
      logic          mfull, mempty, wok, rok;
      logic [WW-1:0] w;
      mfull  = (m_q.size() == 2) && (m_n == RATIO - 1);
      mempty = (m_q.size() == 0);
      wok    = i_write_en && !mfull;
      rok    = o_read_en && !mempty;
      if ((i_write_en && mfull) || (o_read_en && mempty)) m_err = 1'b1;
      @(posedge clk);
      if (rok) m_last = m_q.pop_front();
      if (wok) begin
         m_parts[m_n] = i_data_in;
         m_n++;
         if (m_n == RATIO) begin
            for (int k = 0; k < RATIO; k++) w[k*WIDTH +: WIDTH] = m_parts[k];
            m_q.push_back(w);
            m_n = 0;
         end
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [WW-1:0] exp_data;
      exp_data = (m_q.size() != 0) ? m_q[0] : m_last;
      check({tag, " empty"}, o_empty_out, (m_q.size() == 0));
      check({tag, " full"},  i_full_out,  ((m_q.size() == 2) && (m_n == RATIO - 1)));
      check({tag, " data"},  o_data_out,  exp_data);
`ifdef FABRIC_PORT_OUT_ERR_EN
      check({tag, " error"}, o_error_out, m_err);
`endif
   endtask

   typedef struct {
      logic          we;
      logic          re;
      logic [3:0]    din;
      logic          exp_empty;
      logic          exp_full;
      logic [15:0]   exp_data;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic we, input logic re, input logic [3:0] din,
                               input logic ee, input logic ef, input logic [15:0] ed);
      vec_t v;
      v.we = we; v.re = re; v.din = din;
      v.exp_empty = ee; v.exp_full = ef; v.exp_data = ed;
      vecs.push_back(v);
   endfunction

   initial begin
      int rp;

      // Single word a,b,c,d then pop
      add(1, 0, 4'ha, 1, 0, 16'h0000);
      add(1, 0, 4'hb, 1, 0, 16'h0000);
      add(1, 0, 4'hc, 1, 0, 16'h0000);
      add(1, 0, 4'hd, 0, 0, 16'hdcba);
      add(0, 1, 4'h0, 1, 0, 16'hdcba);
      // Backpressure: flits 1..b with no reads
      for (int f = 1; f <= 3; f++) add(1, 0, 4'(f), 1, 0, 16'hdcba);
      for (int f = 4; f <= 10; f++) add(1, 0, 4'(f), 0, 0, 16'h4321);
      add(1, 0, 4'hb, 0, 1, 16'h4321);
      add(1, 0, 4'hc, 0, 1, 16'h4321);   // held flit while full: dropped
      add(0, 1, 4'h0, 0, 0, 16'h8765);
      add(1, 0, 4'hc, 0, 0, 16'h8765);
      add(0, 1, 4'h0, 0, 0, 16'hcba9);
      add(0, 1, 4'h0, 1, 0, 16'hcba9);
      // Simultaneous push/pop at occ = 1
      for (int f = 1; f <= 3; f++) add(1, 0, 4'(f), 1, 0, 16'hcba9);
      for (int f = 4; f <= 7; f++) add(1, 0, 4'(f), 0, 0, 16'h4321);
      add(1, 1, 4'h8, 0, 0, 16'h8765);
      add(0, 1, 4'h0, 1, 0, 16'h8765);
      add(0, 1, 4'h0, 1, 0, 16'h8765);   // read while empty: ignored

      clear = 1'b1; i_write_en = 1'b0; o_read_en = 1'b0; i_data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset empty", o_empty_out, 1);
      check("reset full",  i_full_out,  0);
      check("reset data",  o_data_out,  16'h0000);
`ifdef FABRIC_PORT_OUT_ERR_EN
      check("reset error", o_error_out, 0);
`endif
      model_reset();
      clear = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         i_write_en = vecs[i].we;
         o_read_en  = vecs[i].re;
         i_data_in  = vecs[i].din;
         step();
         check($sformatf("vec%0d empty", i), o_empty_out, vecs[i].exp_empty);
         check($sformatf("vec%0d full", i),  i_full_out,  vecs[i].exp_full);
         check($sformatf("vec%0d data", i),  o_data_out,  vecs[i].exp_data);
      end
`ifdef FABRIC_PORT_OUT_ERR_EN
      check("sticky error", o_error_out, 1);
`endif

      // Reset mid-word: partial 3,7 must be discarded
      o_read_en = 1'b0; i_write_en = 1'b1;
      i_data_in = 4'h3; step();
      i_data_in = 4'h7; step();
      i_write_en = 1'b0;
      clear = 1'b1;
      #2;
      check("async clr empty", o_empty_out, 1);
      check("async clr full",  i_full_out,  0);
      check("async clr data",  o_data_out,  16'h0000);
`ifdef FABRIC_PORT_OUT_ERR_EN
      check("async clr error", o_error_out, 0);
`endif
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      i_write_en = 1'b1;
      i_data_in = 4'he; step();
      i_data_in = 4'hf; step();
      i_data_in = 4'h1; step();
      i_data_in = 4'h2; step();
      check("midword data",  o_data_out,  16'h21fe);
      check("midword empty", o_empty_out, 0);

      // Random traffic with varying reader rates to reach both full and empty corners
      for (int ph = 0; ph < 4; ph++) begin
         rp = 10 + ph * 30;
         for (int c = 0; c < 500; c++) begin
            i_write_en = ($urandom_range(0, 99) < 80);
            o_read_en  = ($urandom_range(0, 99) < rp);
            i_data_in  = 4'($urandom);
            step();
            check_model($sformatf("rnd p%0d c%0d", ph, c));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
